// File: rtl/stream_arb_pkg.sv
// Shared types and defaults for the streaming round-robin arbiter.
package stream_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    // Index width that stays legal for any requester count.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_pick import stream_arb_pkg::*; #(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    int  idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Offset 1 first so the previous grantee is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ valid/ready streams onto one channel in bursts.
module stream_rr_arbiter import stream_arb_pkg::*; #(
    parameter  int NUM_REQ   = DEF_NUM_REQ,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int IDX_W     = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    arb_state_e       state;
    logic [7:0]       beat_cnt;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic             any_req;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        req_ready = '0;
        busy      = 1'b0;
        if (state == GRANT) begin
            out_valid           = req_valid[grant_id];
            out_data            = req_data[grant_id*DATA_W +: DATA_W];
            req_ready[grant_id] = out_ready;
            busy                = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            grant_id   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (arb_en && any_req) begin
                        state      <= GRANT;
                        grant_id   <= winner;
                        last_grant <= winner;
                        beat_cnt   <= '0;
                    end
                end
                GRANT: begin
                    // A dropped valid ends the burst; a stalled beat never does.
                    if (!req_valid[grant_id]) begin
                        state <= IDLE;
                    end else if (out_ready) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt == 8'(MAX_BURST - 1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed vector bench for stream_rr_arbiter (MAX_BURST=4 instance plus a MAX_BURST=1 instance).
module tb_stream_rr_arbiter;

    localparam logic [31:0] D  = 32'h44332211;
    localparam logic [31:0] DA = 32'h443322AB;
    localparam logic [31:0] DC = 32'h44CD2211;

    logic        clk = 1'b0;
    logic        rst_n, arb_en, out_ready;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_data;
    logic        out_valid, busy;
    logic [7:0]  out_data;
    logic [1:0]  grant_id;

    logic        b_rst_n, b_arb_en, b_out_ready;
    logic [3:0]  b_req_valid, b_req_ready;
    logic [31:0] b_req_data;
    logic        b_out_valid, b_busy;
    logic [7:0]  b_out_data;
    logic [1:0]  b_grant_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .grant_id(grant_id), .busy(busy)
    );

    stream_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst_n(b_rst_n), .arb_en(b_arb_en), .req_valid(b_req_valid),
        .req_data(b_req_data), .req_ready(b_req_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_ready(b_out_ready), .grant_id(b_grant_id), .busy(b_busy)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [3:0]  rv;
        logic [31:0] data;
        logic        ordy;
        logic        eov;
        logic [7:0]  eod;
        logic [3:0]  err;
        logic [1:0]  egid;
        logic        ebusy;
    } vec_t;

    vec_t vecs[$];

    function automatic void idle_r(input logic rst, input logic en, input logic [3:0] rv,
                                   input logic [31:0] d, input logic [1:0] gid);
        vec_t v;
        v.rst_n = rst; v.en = en; v.rv = rv; v.data = d; v.ordy = 1'b1;
        v.eov = 1'b0; v.eod = 8'h00; v.err = 4'b0000; v.egid = gid; v.ebusy = 1'b0;
        vecs.push_back(v);
    endfunction

    function automatic void grant_r(input logic rst, input logic en, input logic [3:0] rv,
                                    input logic [31:0] d, input logic ordy, input logic [1:0] gid);
        vec_t v;
        v.rst_n = rst; v.en = en; v.rv = rv; v.data = d; v.ordy = ordy;
        v.eov = rv[gid]; v.eod = d[gid*8 +: 8];
        v.err = ordy ? (4'b0001 << gid) : 4'b0000;
        v.egid = gid; v.ebusy = 1'b1;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    initial begin
        // single requester, data AB, four beats then a bubble and re-win
        idle_r(1, 1, 4'b0001, DA, 0);
        repeat (4) grant_r(1, 1, 4'b0001, DA, 1, 0);
        idle_r(1, 1, 4'b0001, DA, 0);
        grant_r(1, 1, 4'b0000, DA, 1, 0);
        idle_r(1, 1, 4'b0000, DA, 0);
        idle_r(1, 1, 4'b0000, DA, 0);
        idle_r(0, 1, 4'b1111, D, 0);
        // all requesting: order 0,1,2,3,0 with four beats each
        idle_r(1, 1, 4'b1111, D, 0);
        for (int g = 0; g < 4; g++) begin
            repeat (4) grant_r(1, 1, 4'b1111, D, 1, 2'(g));
            idle_r(1, 1, 4'b1111, D, 2'(g));
        end
        repeat (4) grant_r(1, 1, 4'b1111, D, 1, 0);
        idle_r(1, 1, 4'b0100, DC, 0);
        // grantee 2 stalled for five cycles, then four beats
        repeat (5) grant_r(1, 1, 4'b0100, DC, 0, 2);
        repeat (4) grant_r(1, 1, 4'b0100, DC, 1, 2);
        idle_r(1, 1, 4'b1111, D, 2);
        // grantee 3 drops valid after two beats
        repeat (2) grant_r(1, 1, 4'b1111, D, 1, 3);
        grant_r(1, 1, 4'b0111, D, 1, 3);
        idle_r(1, 1, 4'b0111, D, 3);
        // arb_en falls mid-burst
        grant_r(1, 1, 4'b0111, D, 1, 0);
        repeat (3) grant_r(1, 0, 4'b0111, D, 1, 0);
        repeat (3) idle_r(1, 0, 4'b0111, D, 0);
        idle_r(1, 1, 4'b0111, D, 0);
        // reset mid-burst of grantee 1
        repeat (2) grant_r(1, 1, 4'b0111, D, 1, 1);
        grant_r(0, 1, 4'b1111, D, 1, 1);
        idle_r(1, 1, 4'b1111, D, 0);
        grant_r(1, 1, 4'b1111, D, 1, 0);

        rst_n = 1'b0; arb_en = 1'b1; req_valid = 4'b1111; req_data = D; out_ready = 1'b1;
        b_rst_n = 1'b0; b_arb_en = 1'b1; b_req_valid = 4'b1111; b_req_data = D; b_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_data",  32'(out_data),  0);
        chk("rst req_ready", 32'(req_ready), 0);
        chk("rst grant_id",  32'(grant_id),  0);
        chk("rst busy",      32'(busy),      0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; arb_en = vecs[i].en; req_valid = vecs[i].rv;
            req_data = vecs[i].data; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
            chk($sformatf("v%0d out_data",  i), 32'(out_data),  32'(vecs[i].eod));
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].err));
            chk($sformatf("v%0d grant_id",  i), 32'(grant_id),  32'(vecs[i].egid));
            chk($sformatf("v%0d busy",      i), 32'(busy),      32'(vecs[i].ebusy));
        end

        // MAX_BURST=1: strict one-beat round robin with a bubble between grants
        @(negedge clk);
        b_rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("mb1 idle%0d busy", k), 32'(b_busy), 0);
            @(negedge clk);
            #1;
            chk($sformatf("mb1 g%0d busy", k),      32'(b_busy),      1);
            chk($sformatf("mb1 g%0d grant_id", k),  32'(b_grant_id),  32'(k % 4));
            chk($sformatf("mb1 g%0d req_ready", k), 32'(b_req_ready), 32'(4'b0001 << (k % 4)));
            chk($sformatf("mb1 g%0d out_data", k),  32'(b_out_data),  32'(D[(k % 4)*8 +: 8]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
